// File: rtl/seg7_pkg.sv
// Shared constants for the front-panel 7-segment driver: blank pattern,
// segment bit positions and the active-low hex decode table.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Bit positions inside the {g,f,e,d,c,b,a} segment vector
  typedef enum logic [2:0] {
    SEG_A = 3'd0,
    SEG_B = 3'd1,
    SEG_C = 3'd2,
    SEG_D = 3'd3,
    SEG_E = 3'd4,
    SEG_F = 3'd5,
    SEG_G = 3'd6
  } seg_bit_e;

  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational nibble to active-low segment decoder with a dark override.
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dark,
  output logic [6:0] seg
);

  always_comb begin
    seg = dark ? SEG_BLANK : hex2seg(nibble);
  end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed 7-segment scan driver with per-frame input snapshot and anode guard time.
// Optional SEG7_LZ_BLANK_EN: leading-zero blanking of the snapshot (digit 0 always shown).
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned NDIG     = 4,
  parameter int unsigned SCAN_DIV = 50_000,
  parameter int unsigned GUARD    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [4*NDIG-1:0] value,
  input  logic [NDIG-1:0]   dp_in,
  input  logic [NDIG-1:0]   blank_in,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic              frame_start
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam int unsigned IW = $clog2(NDIG);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);

  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [4*NDIG-1:0] snap_value;
  logic [NDIG-1:0]   snap_dp;
  logic [NDIG-1:0]   snap_blank;
  logic [NDIG-1:0]   lz_mask;
  logic [NDIG-1:0]   dark_mask;
  logic [NDIG-1:0]   an_sel;
  logic [3:0]        nibble;
  logic [6:0]        seg_dec;
  logic              tick;
  logic              frame_wrap;

  assign tick       = (cnt == CNT_LAST);
  assign frame_wrap = tick && (idx == IDX_LAST);

`ifdef SEG7_LZ_BLANK_EN
  // Scan from the leftmost digit down; everything above the first nonzero nibble is dark.
  always_comb begin
    logic seen;
    seen    = 1'b0;
    lz_mask = '0;
    for (int unsigned i = NDIG - 1; i >= 1; i--) begin
      if (snap_value[4*i +: 4] != 4'h0) seen = 1'b1;
      lz_mask[i] = ~seen;
    end
  end
`else
  always_comb begin
    lz_mask = '0;
  end
`endif

  always_comb begin
    dark_mask = snap_blank | lz_mask;
    nibble    = snap_value[{idx, 2'b00} +: 4];
    an_sel    = '1;
    an_sel[idx] = 1'b0;
  end

  seg7_hex_dec u_dec (
    .nibble (nibble),
    .dark   (dark_mask[idx]),
    .seg    (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      idx         <= '0;
      snap_value  <= '0;
      snap_dp     <= '0;
      snap_blank  <= '0;
      an          <= '1;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      an          <= (en && (cnt >= CNT_GUARD)) ? an_sel : '1;
      seg         <= seg_dec;
      dp          <= ~(snap_dp[idx] & ~dark_mask[idx]);
      frame_start <= en & frame_wrap;

      // While idle the snapshot tracks the inputs so enabling shows current data at once.
      if (!en) begin
        cnt        <= '0;
        idx        <= '0;
        snap_value <= value;
        snap_dp    <= dp_in;
        snap_blank <= blank_in;
      end else if (tick) begin
        cnt <= '0;
        if (idx == IDX_LAST) begin
          idx        <= '0;
          snap_value <= value;
          snap_dp    <= dp_in;
          snap_blank <= blank_in;
        end else begin
          idx <= idx + 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan (NDIG=4, SCAN_DIV=8, GUARD=2) against a frame-position model.
module tb_seg7_scan;

  localparam int unsigned NDIG     = 4;
  localparam int unsigned SCAN_DIV = 8;
  localparam int unsigned GUARD    = 2;
  localparam int unsigned FRAME    = NDIG * SCAN_DIV;

  localparam logic [6:0] HEX_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  always #5 clk = ~clk;

  seg7_scan #(
    .NDIG     (NDIG),
    .SCAN_DIV (SCAN_DIV),
    .GUARD    (GUARD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .value       (value),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // Reference model: position within the frame plus the captured snapshot.
  int unsigned pos = 0;
  logic [15:0] m_value = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  m_blank = '0;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_fs;
  bit          e_visible;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit lz_dark(input logic [15:0] v, input int unsigned slot);
`ifdef SEG7_LZ_BLANK_EN
    return (slot != 0) && ((v >> (4 * slot)) == 16'h0);
`else
    return (v == 16'hFFFF) && (slot > NDIG);
`endif
  endfunction

  task automatic model_edge(input bit r, input bit e, input logic [15:0] v,
                            input logic [3:0] d, input logic [3:0] b);
    int unsigned slot, off;
    bit dark;
    logic [3:0] nib;
    slot = pos / SCAN_DIV;
    off  = pos % SCAN_DIV;
    if (!r) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0; e_visible = 1'b1;
      pos = 0; m_value = '0; m_dp = '0; m_blank = '0;
    end else begin
      nib   = 4'(m_value >> (4 * slot));
      dark  = m_blank[slot] || lz_dark(m_value, slot);
      e_seg = dark ? 7'h7F : HEX_TBL[nib];
      e_dp  = !(m_dp[slot] && !dark);
      if (!e) begin
        e_an = 4'hF; e_fs = 1'b0; e_visible = 1'b0;
        pos = 0; m_value = v; m_dp = d; m_blank = b;
      end else begin
        e_an = (off >= GUARD) ? 4'(~(4'b0001 << slot)) : 4'hF;
        e_fs = (pos == FRAME - 1);
        e_visible = 1'b1;
        pos = (pos + 1) % FRAME;
        if (e_fs) begin m_value = v; m_dp = d; m_blank = b; end
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input logic [15:0] v,
                      input logic [3:0] d, input logic [3:0] b);
    @(negedge clk);
    rst_n = r; en = e; value = v; dp_in = d; blank_in = b;
    @(posedge clk);
    model_edge(r, e, v, d, b);
    #1;
    check("an", 32'(an), 32'(e_an));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    if (e_visible) begin
      check("seg", 32'(seg), 32'(e_seg));
      check("dp", 32'(dp), 32'(e_dp));
    end
  endtask

  typedef struct {
    int unsigned edge_no;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        fs;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int unsigned vi;
    int unsigned fs_count, first_fs, last_fs, slot;
    bit seen_fs;
    logic [6:0] hi_seg, lo_seg;

    vecs[0]  = '{1,  4'hF, 7'h0E, 1'b0};
    vecs[1]  = '{2,  4'hF, 7'h0E, 1'b0};
    vecs[2]  = '{3,  4'hE, 7'h0E, 1'b0};
    vecs[3]  = '{8,  4'hE, 7'h0E, 1'b0};
    vecs[4]  = '{9,  4'hF, 7'h08, 1'b0};
    vecs[5]  = '{11, 4'hD, 7'h08, 1'b0};
    vecs[6]  = '{19, 4'hB, 7'h24, 1'b0};
    vecs[7]  = '{27, 4'h7, 7'h79, 1'b0};
    vecs[8]  = '{31, 4'h7, 7'h79, 1'b0};
    vecs[9]  = '{32, 4'h7, 7'h79, 1'b1};
    vecs[10] = '{33, 4'hF, 7'h0E, 1'b0};

    // Reset held with en=1
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h12AF, 4'h0, 4'h0);

    // Load 12AF while idle, then scan and compare against the hand table
    step(1'b1, 1'b0, 16'h12AF, 4'h0, 4'h0);
    vi = 0;
    for (int unsigned k = 1; k <= 40; k++) begin
      step(1'b1, 1'b1, 16'h12AF, 4'h0, 4'h0);
      if (vi < 11 && vecs[vi].edge_no == k) begin
        check("tbl_an", 32'(an), 32'(vecs[vi].an));
        check("tbl_seg", 32'(seg), 32'(vecs[vi].seg));
        check("tbl_fs", 32'(frame_start), 32'(vecs[vi].fs));
        vi++;
      end
    end

    // Mid-frame change to 8888: old digits persist until frame_start
    fs_count = 0; first_fs = 0; last_fs = 0; seen_fs = 1'b0;
    for (int unsigned k = 1; k <= 70; k++) begin
      step(1'b1, 1'b1, 16'h8888, 4'h0, 4'h0);
      if (seen_fs) check("new_seg", 32'(seg), 32'h00);
      else check("old_seg_kept", 32'(seg == 7'h00), 32'h0);
      if (frame_start) begin
        if (fs_count == 0) first_fs = k;
        last_fs = k;
        fs_count++;
        seen_fs = 1'b1;
      end
    end
    check("fs_count", fs_count, 2);
    check("fs_period", last_fs - first_fs, FRAME);

    // en=0 during slot 2, then restart with dp on digit 0
    for (int i = 0; i < 32 && (pos / SCAN_DIV) != 2; i++) step(1'b1, 1'b1, 16'h8888, 4'h0, 4'h0);
    step(1'b1, 1'b1, 16'h8888, 4'h0, 4'h0);
    step(1'b1, 1'b0, 16'h8888, 4'h1, 4'h0);
    check("en_off_an", 32'(an), 32'hF);
    for (int unsigned k = 1; k <= 32; k++) begin
      step(1'b1, 1'b1, 16'h8888, 4'h1, 4'h0);
      slot = (k - 1) / SCAN_DIV;
      check("dp_slot", 32'(dp), (slot == 0) ? 32'h0 : 32'h1);
      if (k == 3) check("restart_an", 32'(an), 32'hE);
    end

    // Leading zeros
`ifdef SEG7_LZ_BLANK_EN
    hi_seg = 7'h7F;
`else
    hi_seg = 7'h40;
`endif
    for (int pass = 0; pass < 2; pass++) begin
      logic [15:0] v;
      v = (pass == 0) ? 16'h0005 : 16'h0000;
      lo_seg = (pass == 0) ? 7'h12 : 7'h40;
      step(1'b1, 1'b0, v, 4'hF, 4'h0);
      for (int unsigned k = 1; k <= 32; k++) begin
        step(1'b1, 1'b1, v, 4'hF, 4'h0);
        slot = (k - 1) / SCAN_DIV;
        check("lz_seg", 32'(seg), (slot == 0) ? 32'(lo_seg) : 32'(hi_seg));
      end
    end

    // Reset and en=0 together: reset wins
    step(1'b0, 1'b0, 16'h1234, 4'hF, 4'h0);
    check("rst_en0_seg", 32'(seg), 32'h7F);

    // Randomized traffic against the model
    begin
      logic [15:0] v;
      logic [3:0] d, b;
      bit e;
      v = 16'h0;
      d = '0;
      b = '0;
      e = 1'b1;
      for (int i = 0; i < 900; i++) begin
        if ($urandom_range(0, 15) == 0) v = 16'($urandom);
        if ($urandom_range(0, 7) == 0) v = 16'($urandom_range(0, 255));
        if ($urandom_range(0, 19) == 0) d = 4'($urandom);
        if ($urandom_range(0, 29) == 0) b = 4'($urandom);
        if ($urandom_range(0, 24) == 0) e = ~e;
        step($urandom_range(0, 79) != 0, e, v, d, b);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
